// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : line_mem_responder
//  Purpose  : Multi-cycle main-memory responder that acts as the shared
//             backing store under the I/D cache controller. Stores 2^ADDR_W
//             lines of DATA_W bits. Each read or write completes a fixed
//             number of cycles after it is accepted, which is signalled by a
//             one-cycle rdy pulse.
//  Ports    : clk      - system clock, rising edge
//             rst      - asynchronous active-high reset
//             addr     - line address, sampled on accept
//             re / we  - read / write request (we wins when both are high)
//             wdata    - write line, sampled on accept
//             rd_data  - registered read line, held until the next read
//             rdy      - one-cycle completion pulse
//             busy     - high while an access is in flight
//  Config   : LINE_MEM_FAST_READ_EN - when defined, reads complete on the
//             accept edge (rdy one cycle after the request); writes keep
//             LATENCY.
//  Revision : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 4     // legal range 2..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy,
    output logic              busy
);

    localparam int C_CNT_W = 4;

    localparam logic [C_CNT_W-1:0] C_LOAD_WR = C_CNT_W'(LATENCY - 1);
`ifdef LINE_MEM_FAST_READ_EN
    localparam logic [C_CNT_W-1:0] C_LOAD_RD = '0;
`else
    localparam logic [C_CNT_W-1:0] C_LOAD_RD = C_CNT_W'(LATENCY - 1);
`endif

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_BUSY = 1'b1;

    // State and access context
    logic [0:0]         state_q,   state_d;
    logic [C_CNT_W-1:0] cnt_q,     cnt_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [DATA_W-1:0]  wdata_q,   wdata_d;
    logic               op_wr_q,   op_wr_d;

    // Registered outputs
    logic               rdy_q,     rdy_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    // Line storage; deliberately has no reset
    logic [DATA_W-1:0]  mem_q [2**ADDR_W];

    logic               w_req;
    logic               w_fin_busy;
    logic               w_fin_fast;
    logic               w_mem_we;

    assign w_req = re | we;

    // Completion of a counted access: the counter steps to zero on this edge.
    assign w_fin_busy = (state_q == C_ST_BUSY) && (cnt_q <= C_CNT_W'(1));

`ifdef LINE_MEM_FAST_READ_EN
    // A read accepted in IDLE with a zero load finishes on the accept edge
    // itself, so it never enters BUSY.
    assign w_fin_fast = (state_q == C_ST_IDLE) && re && !we;
`else
    assign w_fin_fast = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= C_ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            rdy_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            op_wr_q   <= op_wr_d;
            rdy_q     <= rdy_d;
            rd_data_q <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_wr_d = we;
                    cnt_d   = we ? C_LOAD_WR : C_LOAD_RD;
                    if (!w_fin_fast) begin
                        state_d = C_ST_BUSY;
                    end
                end
            end
            C_ST_BUSY: begin
                // Inputs are ignored here; the access always runs to the end.
                cnt_d = cnt_q - C_CNT_W'(1);
                if (w_fin_busy) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        rdy_d     = w_fin_busy | w_fin_fast;
        rd_data_d = rd_data_q;
        w_mem_we  = w_fin_busy && op_wr_q;
        if (w_fin_busy && !op_wr_q) begin
            rd_data_d = mem_q[addr_q];
        end
        if (w_fin_fast) begin
            rd_data_d = mem_q[addr];
        end
    end

    // A reset mid-access returns the FSM to IDLE asynchronously, so a
    // pending write can never reach this port afterwards.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign rd_data = rd_data_q;
    assign rdy     = rdy_q;
    assign busy    = (state_q == C_ST_BUSY);

endmodule
`default_nettype wire
